// File: rtl/udp_tx_packetizer.sv
// UDP transmit packetizer: buffers one packet of DATA_W-bit words, then offers the UDP header and the byte payload.
// Optional counters stat_tx_pkts/stat_tx_drops are present only when UDP_TX_STATS_EN is defined.
module udp_tx_packetizer #(
   parameter int DATA_W    = 64,
   parameter int MAX_WORDS = 184,
   parameter int TTL       = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din_data,
   input  logic              din_valid,
   input  logic              din_last,
   input  logic [3:0]        din_last_bytes,
   output logic              din_ready,
   output logic              tx_udp_hdr_valid,
   input  logic              tx_udp_hdr_ready,
   output logic [5:0]        tx_udp_ip_dscp,
   output logic [1:0]        tx_udp_ip_ecn,
   output logic [7:0]        tx_udp_ip_ttl,
   output logic [31:0]       tx_udp_ip_source_ip,
   output logic [31:0]       tx_udp_ip_dest_ip,
   output logic [15:0]       tx_udp_source_port,
   output logic [15:0]       tx_udp_dest_port,
   output logic [15:0]       tx_udp_length,
   output logic [15:0]       tx_udp_checksum,
   output logic [7:0]        tx_udp_payload_axis_tdata,
   output logic              tx_udp_payload_axis_tvalid,
   input  logic              tx_udp_payload_axis_tready,
   output logic              tx_udp_payload_axis_tlast,
   output logic              tx_udp_payload_axis_tuser,
   output logic              tx_drop,
`ifdef UDP_TX_STATS_EN
   output logic [31:0]       stat_tx_pkts,
   output logic [31:0]       stat_tx_drops,
`endif
   input  logic [31:0]       local_ip,
   input  logic [31:0]       dest_ip,
   input  logic [15:0]       local_port,
   input  logic [15:0]       dest_port
);

   localparam int          BPW   = DATA_W / 8;
   localparam int          CW    = $clog2(MAX_WORDS + 1);
   localparam int          IW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [3:0]  BPW4  = 4'(BPW);
   localparam logic [15:0] BPW16 = 16'(BPW);

   typedef enum logic [1:0] {S_FILL, S_HDR, S_PAYLOAD, S_DROP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_buf [MAX_WORDS];
   logic [CW-1:0]       r_wcnt;
   logic [IW-1:0]       r_raddr;
   logic [DATA_W-1:0]   r_word;
   logic [15:0]         r_byte_len;
   logic [15:0]         r_bidx;
   logic                r_din_ready;
   logic [31:0]         r_src_ip, r_dst_ip;
   logic [15:0]         r_src_port, r_dst_port;

   logic                w_acc, w_full, w_hdr_hs, w_byte_hs, w_tlast, w_word_end, w_drop_done;
   logic [15:0]         w_last_bytes, w_byte_len;

   assign w_acc        = din_valid && r_din_ready;
   assign w_full       = (r_wcnt == CW'(MAX_WORDS));
   assign w_last_bytes = (din_last_bytes == 4'd0 || din_last_bytes > BPW4) ? BPW16 : {12'd0, din_last_bytes};
   assign w_byte_len   = 16'(r_wcnt) * BPW16 + w_last_bytes;
   assign w_hdr_hs     = (r_state == S_HDR) && tx_udp_hdr_ready;
   assign w_byte_hs    = (r_state == S_PAYLOAD) && tx_udp_payload_axis_tready;
   assign w_tlast      = (r_bidx == r_byte_len - 16'd1);
   assign w_word_end   = ((r_bidx & (BPW16 - 16'd1)) == (BPW16 - 16'd1));
   assign w_drop_done  = w_acc && din_last && ((r_state == S_DROP) || (r_state == S_FILL && w_full));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FILL;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_FILL: begin
            if (w_acc) begin
               if (w_full) begin
                  if (!din_last) w_state_nxt = S_DROP;
               end else if (din_last) begin
                  w_state_nxt = S_HDR;
               end
            end
         end
         S_HDR:     if (tx_udp_hdr_ready) w_state_nxt = S_PAYLOAD;
         S_PAYLOAD: if (tx_udp_payload_axis_tready && w_tlast) w_state_nxt = S_FILL;
         S_DROP:    if (w_acc && din_last) w_state_nxt = S_FILL;
         default:   w_state_nxt = S_FILL;
      endcase
   end

   // NOTE: the packet buffer has no reset; stale contents are never read because wcnt restarts at 0.
   always_ff @(posedge clk) begin
      if (r_state == S_FILL && w_acc && !w_full) r_buf[r_wcnt[IW-1:0]] <= din_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din_ready <= 1'b0;
         r_wcnt      <= '0;
         r_raddr     <= '0;
         r_word      <= '0;
         r_byte_len  <= '0;
         r_bidx      <= '0;
         r_src_ip    <= '0;
         r_dst_ip    <= '0;
         r_src_port  <= '0;
         r_dst_port  <= '0;
      end else begin
         r_din_ready <= (w_state_nxt == S_FILL) || (w_state_nxt == S_DROP);
         case (r_state)
            S_FILL: begin
               if (w_acc) begin
                  if (w_full) begin
                     if (din_last) r_wcnt <= '0;
                  end else if (din_last) begin
                     r_byte_len <= w_byte_len;
                     r_src_ip   <= local_ip;
                     r_dst_ip   <= dest_ip;
                     r_src_port <= local_port;
                     r_dst_port <= dest_port;
                     r_wcnt     <= '0;
                  end else begin
                     r_wcnt <= r_wcnt + CW'(1);
                  end
               end
            end
            S_DROP: if (w_acc && din_last) r_wcnt <= '0;
            S_HDR: begin
               if (w_hdr_hs) begin
                  r_word  <= r_buf[0];
                  r_raddr <= IW'(1);
                  r_bidx  <= '0;
               end
            end
            S_PAYLOAD: begin
               if (w_byte_hs) begin
                  r_bidx <= r_bidx + 16'd1;
                  // Fetch the next word on the last byte of the current one so the stream has no gaps.
                  if (w_word_end && !w_tlast) begin
                     r_word  <= r_buf[r_raddr];
                     r_raddr <= r_raddr + IW'(1);
                  end else begin
                     r_word <= r_word >> 8;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef UDP_TX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_tx_pkts  <= '0;
         stat_tx_drops <= '0;
      end else begin
         if (w_byte_hs && w_tlast) stat_tx_pkts  <= stat_tx_pkts + 32'd1;
         if (w_drop_done)          stat_tx_drops <= stat_tx_drops + 32'd1;
      end
   end
`endif

   assign din_ready                  = r_din_ready;
   assign tx_udp_hdr_valid           = (r_state == S_HDR);
   assign tx_udp_ip_dscp             = 6'd0;
   assign tx_udp_ip_ecn              = 2'd0;
   assign tx_udp_ip_ttl              = 8'(TTL);
   assign tx_udp_ip_source_ip        = r_src_ip;
   assign tx_udp_ip_dest_ip          = r_dst_ip;
   assign tx_udp_source_port         = r_src_port;
   assign tx_udp_dest_port           = r_dst_port;
   assign tx_udp_length              = r_byte_len + 16'd8;
   assign tx_udp_checksum            = 16'd0;
   assign tx_udp_payload_axis_tdata  = r_word[7:0];
   assign tx_udp_payload_axis_tvalid = (r_state == S_PAYLOAD);
   assign tx_udp_payload_axis_tlast  = (r_state == S_PAYLOAD) && w_tlast;
   assign tx_udp_payload_axis_tuser  = 1'b0;
   assign tx_drop                    = w_drop_done;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Self-checking bench for udp_tx_packetizer: random packets compared against a byte-queue model of the payload.
// Stats checks are included when UDP_TX_STATS_EN is defined.
module tb_udp_tx_packetizer;
   localparam int DATA_W    = 64;
   localparam int BPW       = DATA_W / 8;
   localparam int MAX_WORDS = 184;
   localparam int TTL       = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] din_data = '0;
   logic              din_valid = 1'b0, din_last = 1'b0;
   logic [3:0]        din_last_bytes = '0;
   logic              din_ready;
   logic              hdr_valid, hdr_ready = 1'b0;
   logic [5:0]        dscp;
   logic [1:0]        ecn;
   logic [7:0]        ttl;
   logic [31:0]       src_ip, dst_ip;
   logic [15:0]       src_port, dst_port, udp_len, csum;
   logic [7:0]        tdata;
   logic              tvalid, tready = 1'b0, tlast, tuser, tx_drop;
   logic [31:0]       local_ip = '0, dest_ip = '0;
   logic [15:0]       local_port = '0, dest_port = '0;
`ifdef UDP_TX_STATS_EN
   logic [31:0]       stat_tx_pkts, stat_tx_drops;
`endif

   always #5 clk = ~clk;

   udp_tx_packetizer #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .TTL(TTL)) dut (
      .clk(clk), .rst_n(rst_n),
      .din_data(din_data), .din_valid(din_valid), .din_last(din_last),
      .din_last_bytes(din_last_bytes), .din_ready(din_ready),
      .tx_udp_hdr_valid(hdr_valid), .tx_udp_hdr_ready(hdr_ready),
      .tx_udp_ip_dscp(dscp), .tx_udp_ip_ecn(ecn), .tx_udp_ip_ttl(ttl),
      .tx_udp_ip_source_ip(src_ip), .tx_udp_ip_dest_ip(dst_ip),
      .tx_udp_source_port(src_port), .tx_udp_dest_port(dst_port),
      .tx_udp_length(udp_len), .tx_udp_checksum(csum),
      .tx_udp_payload_axis_tdata(tdata), .tx_udp_payload_axis_tvalid(tvalid),
      .tx_udp_payload_axis_tready(tready), .tx_udp_payload_axis_tlast(tlast),
      .tx_udp_payload_axis_tuser(tuser), .tx_drop(tx_drop),
`ifdef UDP_TX_STATS_EN
      .stat_tx_pkts(stat_tx_pkts), .stat_tx_drops(stat_tx_drops),
`endif
      .local_ip(local_ip), .dest_ip(dest_ip), .local_port(local_port), .dest_port(dest_port)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: payload bytes of the packet in flight and the header it must produce.
   logic [7:0]  tx_q[$];
   logic [31:0] exp_sip, exp_dip;
   logic [15:0] exp_sport, exp_dport;

   // Observations gathered by the drive/collect helpers.
   logic [7:0]  got_q[$];
   logic [15:0] obs_len, obs_sport, obs_dport;
   logic [31:0] obs_sip, obs_dip;
   logic [32:0] obs_const;
   int          obs_hdr_lat, obs_tlast_cnt, obs_tlast_pos, obs_bubbles, obs_unstable, obs_busy_bad;
   bit          obs_timeout, obs_rdy_after, obs_last_drop;

   int drop_pulses = 0;
   int hdr_cycles  = 0;
   always @(negedge clk) begin
      if (tx_drop)   drop_pulses++;
      if (hdr_valid) hdr_cycles++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_packet(input int n_bytes, input int gap_pct);
      int nw = (n_bytes + BPW - 1) / BPW;
      obs_last_drop = 1'b0;
      for (int w = 0; w < nw; w++) begin
         logic [DATA_W-1:0] d;
         int rem, wait_cnt;
         bit acc;
         if ($urandom_range(0, 99) < gap_pct) begin
            din_valid = 1'b0;
            din_data  = {$urandom, $urandom};
            din_last  = 1'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         for (int k = 0; k < BPW; k++)
            d[8*k +: 8] = (w*BPW + k < n_bytes) ? tx_q[w*BPW + k] : 8'($urandom);
         rem = n_bytes - (nw - 1) * BPW;
         din_data       = d;
         din_valid      = 1'b1;
         din_last       = (w == nw - 1);
         din_last_bytes = (w == nw - 1) ? ((rem == BPW && $urandom_range(0, 1) == 1) ? 4'd0 : 4'(rem))
                                        : 4'($urandom);
         wait_cnt = 0;
         do begin
            @(negedge clk);
            acc = din_ready;
            if (acc && din_last) obs_last_drop = tx_drop;
            wait_cnt++;
            @(posedge clk);
            #1;
         end while (!acc && wait_cnt < 2000);
         checks++;
         if (!acc) begin
            errors++;
            $display("FAIL send_accept: word %0d not accepted, din_ready %0b, required 1", w, din_ready);
            din_valid = 1'b0;
            return;
         end
      end
      din_valid = 1'b0;
      din_last  = 1'b0;
   endtask

   task automatic collect_packet(input int n_bytes, input int hdr_delay, input int ready_pct, input int stop_after);
      int n, cyc;
      bit done, stall, stall_l;
      logic [7:0] stall_d;
      got_q.delete();
      obs_tlast_cnt = 0; obs_tlast_pos = -1; obs_bubbles = 0; obs_unstable = 0; obs_busy_bad = 0;
      obs_timeout = 1'b0; obs_rdy_after = 1'b0;
      n = 0;
      @(negedge clk);
      while (!hdr_valid && n < 200) begin
         n++;
         @(negedge clk);
      end
      obs_hdr_lat = n;
      if (!hdr_valid) begin
         obs_timeout = 1'b1;
         @(posedge clk);
         #1;
         return;
      end
      obs_len = udp_len; obs_sip = src_ip; obs_dip = dst_ip; obs_sport = src_port; obs_dport = dst_port;
      obs_const = {dscp, ecn, ttl, csum, tuser};
      for (int i = 0; i < hdr_delay; i++) begin
         @(negedge clk);
         if (!hdr_valid || udp_len !== obs_len || src_ip !== obs_sip || dst_ip !== obs_dip ||
             src_port !== obs_sport || dst_port !== obs_dport) obs_unstable++;
         if (din_ready || tvalid) obs_busy_bad++;
      end
      hdr_ready = 1'b1;
      @(posedge clk);
      #1;
      hdr_ready = 1'($urandom);
      cyc = 0; done = 1'b0; stall = 1'b0; stall_l = 1'b0; stall_d = '0;
      while (!done) begin
         tready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk);
         if (!tvalid) obs_bubbles++;
         if (din_ready) obs_busy_bad++;
         if (stall && (tdata !== stall_d || tlast !== stall_l)) obs_unstable++;
         stall = 1'b0;
         if (tvalid && tready) begin
            got_q.push_back(tdata);
            if (tlast) begin
               obs_tlast_cnt++;
               obs_tlast_pos = got_q.size() - 1;
               done = 1'b1;
            end
         end else if (tvalid) begin
            stall = 1'b1; stall_d = tdata; stall_l = tlast;
         end
         @(posedge clk);
         #1;
         cyc++;
         if (stop_after >= 0 && got_q.size() == stop_after) return;
         if (!done && (cyc > 10 * n_bytes + 200 || got_q.size() > n_bytes + 4)) begin
            obs_timeout = 1'b1;
            done = 1'b1;
         end
      end
      tready    = 1'b0;
      hdr_ready = 1'b0;
      @(negedge clk);
      obs_rdy_after = din_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %0b required 0", din_ready); end
      checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid: got %0b required 0", hdr_valid); end
      checks++; if (tvalid !== 1'b0 || tlast !== 1'b0) begin errors++; $display("FAIL reset_tvalid_tlast: got %0b/%0b required 0/0", tvalid, tlast); end
      checks++; if (tx_drop !== 1'b0) begin errors++; $display("FAIL reset_tx_drop: got %0b required 0", tx_drop); end
`ifdef UDP_TX_STATS_EN
      checks++; if (stat_tx_pkts !== 32'd0 || stat_tx_drops !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d required 0/0", stat_tx_pkts, stat_tx_drops); end
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_release_din_ready: got %0b required 1", din_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_packet(input string name, input int len, input int hdr_delay,
                              input int ready_pct, input int gap_pct, input bit pattern);
      int data_bad = 0;
      int first_bad = -1;
      tx_q.delete();
      for (int i = 0; i < len; i++) tx_q.push_back(pattern ? 8'(i) : 8'($urandom));
      local_ip = $urandom; dest_ip = $urandom; local_port = 16'($urandom); dest_port = 16'($urandom);
      exp_sip = local_ip; exp_dip = dest_ip; exp_sport = local_port; exp_dport = dest_port;
      send_packet(len, gap_pct);
      local_ip = $urandom; dest_ip = $urandom; local_port = 16'($urandom); dest_port = 16'($urandom);
      collect_packet(len, hdr_delay, ready_pct, -1);
      for (int i = 0; i < len && i < got_q.size(); i++)
         if (got_q[i] !== tx_q[i]) begin
            data_bad++;
            if (first_bad < 0) first_bad = i;
         end
      checks++; if (obs_timeout) begin errors++; $display("FAIL %s timeout: got %0d bytes, required %0d", name, got_q.size(), len); end
      checks++; if (obs_hdr_lat != 0) begin errors++; $display("FAIL %s hdr_latency: got %0d cycles late, required 0", name, obs_hdr_lat); end
      checks++; if (obs_len !== 16'(len + 8)) begin errors++; $display("FAIL %s udp_length: got %0d required %0d", name, obs_len, len + 8); end
      checks++; if (obs_sip !== exp_sip || obs_dip !== exp_dip) begin errors++; $display("FAIL %s ip: got %08h/%08h required %08h/%08h", name, obs_sip, obs_dip, exp_sip, exp_dip); end
      checks++; if (obs_sport !== exp_sport || obs_dport !== exp_dport) begin errors++; $display("FAIL %s ports: got %04h/%04h required %04h/%04h", name, obs_sport, obs_dport, exp_sport, exp_dport); end
      checks++; if (obs_const !== {6'd0, 2'd0, 8'(TTL), 16'd0, 1'b0}) begin errors++; $display("FAIL %s const_fields: got %09h required ttl %0d rest 0", name, obs_const, TTL); end
      checks++; if (got_q.size() != len) begin errors++; $display("FAIL %s byte_count: got %0d required %0d", name, got_q.size(), len); end
      checks++; if (data_bad != 0) begin errors++; $display("FAIL %s data: %0d wrong, first at %0d got %02h required %02h", name, data_bad, first_bad, got_q[first_bad], tx_q[first_bad]); end
      checks++; if (obs_tlast_cnt != 1 || obs_tlast_pos != len - 1) begin errors++; $display("FAIL %s tlast: got %0d at %0d required 1 at %0d", name, obs_tlast_cnt, obs_tlast_pos, len - 1); end
      checks++; if (obs_bubbles != 0) begin errors++; $display("FAIL %s tvalid_gaps: got %0d required 0", name, obs_bubbles); end
      checks++; if (obs_unstable != 0) begin errors++; $display("FAIL %s stability: got %0d changes while stalled, required 0", name, obs_unstable); end
      checks++; if (obs_busy_bad != 0) begin errors++; $display("FAIL %s busy_outputs: got %0d bad cycles, required 0", name, obs_busy_bad); end
      checks++; if (obs_rdy_after !== 1'b1) begin errors++; $display("FAIL %s din_ready_after: got %0b required 1", name, obs_rdy_after); end
      checks++; if (obs_last_drop !== 1'b0) begin errors++; $display("FAIL %s spurious_drop: got %0b required 0", name, obs_last_drop); end
   endtask

   task automatic test_overflow(input string name, input int n_words);
      int d0 = drop_pulses;
      int h0 = hdr_cycles;
      tx_q.delete();
      for (int i = 0; i < n_words * BPW; i++) tx_q.push_back(8'($urandom));
      send_packet(n_words * BPW, 10);
      repeat (5) @(posedge clk);
      #1;
      checks++; if (drop_pulses - d0 != 1) begin errors++; $display("FAIL %s drop_pulses: got %0d required 1", name, drop_pulses - d0); end
      checks++; if (obs_last_drop !== 1'b1) begin errors++; $display("FAIL %s drop_on_last: got %0b required 1", name, obs_last_drop); end
      checks++; if (hdr_cycles - h0 != 0) begin errors++; $display("FAIL %s header_emitted: got %0d hdr cycles required 0", name, hdr_cycles - h0); end
      @(negedge clk);
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL %s din_ready_after: got %0b required 1", name, din_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      tx_q.delete();
      for (int i = 0; i < 30; i++) tx_q.push_back(8'($urandom));
      send_packet(30, 0);
      collect_packet(30, 0, 100, 5);
      tready    = 1'b0;
      hdr_ready = 1'b0;
      for (int i = 0; i < 5 && i < got_q.size(); i++) if (got_q[i] !== tx_q[i]) bad++;
      checks++; if (got_q.size() != 5 || bad != 0) begin errors++; $display("FAIL reset_mid_prefix: got %0d bytes %0d wrong, required 5 bytes 0 wrong", got_q.size(), bad); end
      @(negedge clk);
      checks++; if (tvalid !== 1'b1 || tdata !== tx_q[5]) begin errors++; $display("FAIL reset_mid_byte5: got v%0b %02h required v1 %02h", tvalid, tdata, tx_q[5]); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (tvalid !== 1'b0 || tlast !== 1'b0) begin errors++; $display("FAIL reset_mid_async: got tvalid %0b tlast %0b required 0/0", tvalid, tlast); end
      checks++; if (din_ready !== 1'b0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_ready: got %0b/%0b required 0/0", din_ready, hdr_valid); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_packet("post_reset", 45, 1, 70, 20, 1'b0);
   endtask

`ifdef UDP_TX_STATS_EN
   task automatic test_stats;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (stat_tx_pkts !== 32'd0 || stat_tx_drops !== 32'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d required 0/0", stat_tx_pkts, stat_tx_drops); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_packet("stats_a", 17, 0, 100, 0, 1'b0);
      test_packet("stats_b", 64, 2, 60, 10, 1'b0);
      test_overflow("stats_drop", MAX_WORDS + 6);
      test_packet("stats_c", 5, 0, 90, 0, 1'b1);
      @(negedge clk);
      checks++; if (stat_tx_pkts !== 32'd3) begin errors++; $display("FAIL stats_pkts: got %0d required 3", stat_tx_pkts); end
      checks++; if (stat_tx_drops !== 32'd1) begin errors++; $display("FAIL stats_drops: got %0d required 1", stat_tx_drops); end
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      test_reset();
      test_packet("ten_bytes", 10, 0, 100, 0, 1'b1);
      test_packet("hdr_stall", 37, 20, 100, 0, 1'b0);
      test_packet("one_byte", 1, 0, 100, 0, 1'b0);
      test_packet("one_word", BPW, 2, 60, 0, 1'b0);
      for (int i = 0; i < 8; i++)
         test_packet("random", $urandom_range(1, 300), $urandom_range(0, 4), $urandom_range(20, 100), 30, 1'b0);
      test_packet("max_payload", MAX_WORDS * BPW, 0, 50, 0, 1'b0);
      test_overflow("ovf_on_last", MAX_WORDS + 1);
      test_packet("after_ovf_on_last", 3 * BPW, 0, 100, 0, 1'b1);
      test_overflow("ovf_drop_state", MAX_WORDS + 6);
      test_packet("after_ovf_drop", 3 * BPW - 3, 0, 80, 0, 1'b1);
      test_reset_mid();
`ifdef UDP_TX_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
